// File: rtl/uart_echo_fifo_if.sv
// Rx-to-Tx byte handshake bundle for the UART echo engine.
// master is the echo engine side, slave the receiver/transmitter side.
interface uart_echo_fifo_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] ipRxData;
    logic              ipRxValid;
    logic [DATA_W-1:0] opTxData;
    logic              opTxSend;
    logic              ipTxBusy;

    modport master (
        input  ipRxData,
        input  ipRxValid,
        input  ipTxBusy,
        output opTxData,
        output opTxSend
    );

    modport slave (
        output ipRxData,
        output ipRxValid,
        output ipTxBusy,
        input  opTxData,
        input  opTxSend
    );
endinterface

// File: rtl/uart_echo_fifo.sv
// Buffered UART echo engine: Rx bytes queue in a FIFO, are case-transformed
// on dequeue and handed to the transmitter over a level send/busy handshake.
module uart_echo_fifo #(
    parameter int DATA_W      = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int CRLF_EXPAND = 1
) (
    input  logic                        ipClk,
    input  logic                        ipReset,
    input  logic [1:0]                  ipMode,
    uart_echo_fifo_if.master            bus,
    output logic [$clog2(FIFO_DEPTH):0] opFifoCount,
    output logic                        opOverflow,
    input  logic                        ipClearOverflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [DATA_W-1:0] CR_BYTE = DATA_W'(8'h0D);
    localparam logic [DATA_W-1:0] LF_BYTE = DATA_W'(8'h0A);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wrPtr;
    logic [AW-1:0]     rdPtr;
    logic [1:0]        state;
    logic              lfPending;

    logic              full;
    logic              empty;
    logic              pop;
    logic              push;
    logic              drop;
    logic [DATA_W-1:0] popData;
    logic [DATA_W-1:0] xformData;

    assign full    = (opFifoCount == FULL_CNT);
    assign empty   = (opFifoCount == '0);
    assign pop     = (state == IDLE) && !empty && !bus.ipTxBusy;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push    = bus.ipRxValid && (!full || pop);
    assign drop    = bus.ipRxValid && full && !pop;
    assign popData = mem[rdPtr];

    // Case transforms only make sense for 8-bit ASCII bytes.
    if (DATA_W == 8) begin : gXform
        logic isUpper;
        logic isLower;

        assign isUpper = (popData >= 8'h41) && (popData <= 8'h5A);
        assign isLower = (popData >= 8'h61) && (popData <= 8'h7A);

        // Apply the selected case transform to the byte at the FIFO head.
        always_comb begin
            xformData = popData;
            case (ipMode)
                2'd1: if (isUpper || isLower) xformData = popData ^ 8'h20;
                2'd2: if (isLower) xformData = popData - 8'h20;
                2'd3: if (isUpper) xformData = popData + 8'h20;
                default: xformData = popData;
            endcase
        end
    end else begin : gPass
        assign xformData = popData;
    end

    // FIFO storage write; stale contents are harmless since pointers reset.
    always_ff @(posedge ipClk) begin
        if (push) mem[wrPtr] <= bus.ipRxData;
    end

    // Pointers and occupancy count.
    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            wrPtr       <= '0;
            rdPtr       <= '0;
            opFifoCount <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_ONE;
            if (pop)  rdPtr <= rdPtr + PTR_ONE;
            case ({push, pop})
                2'b10:   opFifoCount <= opFifoCount + CNT_ONE;
                2'b01:   opFifoCount <= opFifoCount - CNT_ONE;
                default: opFifoCount <= opFifoCount;
            endcase
        end
    end

    // Sticky overflow flag; a new drop beats a simultaneous clear.
    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            opOverflow <= 1'b0;
        end else if (drop) begin
            opOverflow <= 1'b1;
        end else if (ipClearOverflow) begin
            opOverflow <= 1'b0;
        end
    end

    // Transmit handshake FSM with optional CR -> CR LF expansion.
    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            state        <= IDLE;
            bus.opTxSend <= 1'b0;
            bus.opTxData <= '0;
            lfPending    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        bus.opTxData <= xformData;
                        bus.opTxSend <= 1'b1;
                        lfPending    <= (CRLF_EXPAND == 1) &&
                                        (popData == CR_BYTE);
                        state        <= SEND;
                    end
                end
                SEND: begin
                    if (bus.ipTxBusy) begin
                        bus.opTxSend <= 1'b0;
                        state        <= WAIT;
                    end
                end
                WAIT: begin
                    if (!bus.ipTxBusy) begin
                        if (lfPending) begin
                            bus.opTxData <= LF_BYTE;
                            bus.opTxSend <= 1'b1;
                            lfPending    <= 1'b0;
                            state        <= SEND;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    bus.opTxSend <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_echo_fifo.sv
// Directed bench for uart_echo_fifo with a behavioural transmitter model.
// Two instances run side by side: CR LF expansion on (dut0) and off (dut1).
module tb_uart_echo_fifo;
    localparam int DEPTH   = 16;
    localparam int BUSYLEN = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic [7:0] rxData;
    logic       rxValid;
    logic       clrOvf;
    logic       holdBusy;
    logic [4:0] cnt0;
    logic [4:0] cnt1;
    logic       ovf0;
    logic       ovf1;

    int checks   = 0;
    int failures = 0;
    int peak     = 0;

    always #5 clk = ~clk;

    uart_echo_fifo_if #(.DATA_W(8)) bus0 ();
    uart_echo_fifo_if #(.DATA_W(8)) bus1 ();

    logic mBusy0 = 1'b0;
    logic mBusy1 = 1'b0;
    int   mCnt0  = 0;
    int   mCnt1  = 0;
    logic [7:0] log0 [$];
    logic [7:0] log1 [$];

    assign bus0.ipRxData  = rxData;
    assign bus0.ipRxValid = rxValid;
    assign bus0.ipTxBusy  = holdBusy | mBusy0;
    assign bus1.ipRxData  = rxData;
    assign bus1.ipRxValid = rxValid;
    assign bus1.ipTxBusy  = holdBusy | mBusy1;

    uart_echo_fifo #(
        .DATA_W(8), .FIFO_DEPTH(DEPTH), .CRLF_EXPAND(1)
    ) dut0 (
        .ipClk(clk), .ipReset(rst), .ipMode(mode), .bus(bus0.master),
        .opFifoCount(cnt0), .opOverflow(ovf0),
        .ipClearOverflow(clrOvf)
    );

    uart_echo_fifo #(
        .DATA_W(8), .FIFO_DEPTH(DEPTH), .CRLF_EXPAND(0)
    ) dut1 (
        .ipClk(clk), .ipReset(rst), .ipMode(mode), .bus(bus1.master),
        .opFifoCount(cnt1), .opOverflow(ovf1),
        .ipClearOverflow(clrOvf)
    );

    // Transmitter model: accepts a send when idle, then busy BUSYLEN cycles.
    always @(posedge clk) begin
        if (mBusy0) begin
            if (mCnt0 <= 1) mBusy0 <= 1'b0;
            else mCnt0 <= mCnt0 - 1;
        end else if (bus0.opTxSend && !holdBusy) begin
            mBusy0 <= 1'b1;
            mCnt0  <= BUSYLEN;
            log0.push_back(bus0.opTxData);
        end
    end

    // Same transmitter model for the non-expanding instance.
    always @(posedge clk) begin
        if (mBusy1) begin
            if (mCnt1 <= 1) mBusy1 <= 1'b0;
            else mCnt1 <= mCnt1 - 1;
        end else if (bus1.opTxSend && !holdBusy) begin
            mBusy1 <= 1'b1;
            mCnt1  <= BUSYLEN;
            log1.push_back(bus1.opTxData);
        end
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic trackPeak();
        if (int'(cnt0) > peak) peak = int'(cnt0);
    endtask

    task automatic push(logic [7:0] b);
        rxData  = b;
        rxValid = 1'b1;
        @(negedge clk);
        rxValid = 1'b0;
        trackPeak();
    endtask

    task automatic waitDrain();
        int quiet = 0;
        for (int i = 0; i < 3000 && quiet < 3; i++) begin
            @(negedge clk);
            trackPeak();
            if (cnt0 == 0 && cnt1 == 0 && !bus0.opTxSend &&
                !bus1.opTxSend && !mBusy0 && !mBusy1)
                quiet++;
            else
                quiet = 0;
        end
        check("drain_done", 32'(quiet >= 3), 32'd1);
    endtask

    initial begin
        rst      = 1'b1;
        mode     = 2'd0;
        rxData   = 8'h00;
        rxValid  = 1'b0;
        clrOvf   = 1'b0;
        holdBusy = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_count", 32'(cnt0), 32'd0);
        check("rst_ovf", 32'(ovf0), 32'd0);
        check("rst_send", 32'(bus0.opTxSend), 32'd0);
        check("rst_data", 32'(bus0.opTxData), 32'h00);
        rst = 1'b0;
        @(negedge clk);

        // Mode 0 single byte, latency and handshake timing.
        rxData  = 8'h41;
        rxValid = 1'b1;
        @(negedge clk);
        rxValid = 1'b0;
        check("m0_cnt_after_push", 32'(cnt0), 32'd1);
        check("m0_send_not_yet", 32'(bus0.opTxSend), 32'd0);
        @(negedge clk);
        check("m0_send_high", 32'(bus0.opTxSend), 32'd1);
        check("m0_data", 32'(bus0.opTxData), 32'h41);
        check("m0_cnt_popped", 32'(cnt0), 32'd0);
        @(negedge clk);
        check("m0_busy_rose", 32'(mBusy0), 32'd1);
        check("m0_send_held", 32'(bus0.opTxSend), 32'd1);
        @(negedge clk);
        check("m0_send_dropped", 32'(bus0.opTxSend), 32'd0);
        waitDrain();
        check("m0_log_size", 32'(log0.size()), 32'd1);
        check("m0_log0", 32'(log0[0]), 32'h41);

        // Mode 1 toggle case, back-to-back, transmitter free.
        log0.delete();
        log1.delete();
        mode = 2'd1;
        peak = 0;
        push(8'h61);
        push(8'h5A);
        push(8'h33);
        waitDrain();
        check("m1_peak", 32'(peak), 32'd2);
        check("m1_log_size", 32'(log0.size()), 32'd3);
        check("m1_log0", 32'(log0[0]), 32'h41);
        check("m1_log1", 32'(log0[1]), 32'h7A);
        check("m1_log2", 32'(log0[2]), 32'h33);

        // Mode 1 with the transmitter held busy: all three queue up.
        log0.delete();
        log1.delete();
        holdBusy = 1'b1;
        push(8'h61);
        push(8'h5A);
        push(8'h33);
        check("m1_hold_cnt", 32'(cnt0), 32'd3);
        holdBusy = 1'b0;
        waitDrain();
        check("m1h_log_size", 32'(log0.size()), 32'd3);
        check("m1h_log0", 32'(log0[0]), 32'h41);
        check("m1h_log1", 32'(log0[1]), 32'h7A);
        check("m1h_log2", 32'(log0[2]), 32'h33);

        // Mode 2 then mode 3, including non-letter neighbours.
        log0.delete();
        log1.delete();
        mode = 2'd2;
        push(8'h71);
        push(8'h40);
        waitDrain();
        mode = 2'd3;
        push(8'h51);
        push(8'h5B);
        waitDrain();
        check("m23_log_size", 32'(log0.size()), 32'd4);
        check("m2_q", 32'(log0[0]), 32'h51);
        check("m2_at", 32'(log0[1]), 32'h40);
        check("m3_Q", 32'(log0[2]), 32'h71);
        check("m3_brk", 32'(log0[3]), 32'h5B);

        // CR expansion on dut0, none on dut1.
        log0.delete();
        log1.delete();
        mode = 2'd0;
        push(8'h0D);
        push(8'h31);
        waitDrain();
        check("crlf_size", 32'(log0.size()), 32'd3);
        check("crlf_0", 32'(log0[0]), 32'h0D);
        check("crlf_1", 32'(log0[1]), 32'h0A);
        check("crlf_2", 32'(log0[2]), 32'h31);
        check("nocrlf_size", 32'(log1.size()), 32'd2);
        check("nocrlf_0", 32'(log1[0]), 32'h0D);
        check("nocrlf_1", 32'(log1[1]), 32'h31);

        // Overflow: fill past depth while the transmitter is held busy.
        log0.delete();
        log1.delete();
        holdBusy = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) push(8'(8'h30 + i));
        check("ovf_cnt_full", 32'(cnt0), 32'd16);
        check("ovf_set", 32'(ovf0), 32'd1);
        clrOvf = 1'b1;
        push(8'h50);
        clrOvf = 1'b0;
        check("ovf_set_wins", 32'(ovf0), 32'd1);
        clrOvf = 1'b1;
        @(negedge clk);
        clrOvf = 1'b0;
        check("ovf_cleared", 32'(ovf0), 32'd0);
        check("ovf_cnt_kept", 32'(cnt0), 32'd16);
        holdBusy = 1'b0;
        push(8'h7E);
        check("full_pushpop_cnt", 32'(cnt0), 32'd16);
        check("full_pushpop_ovf", 32'(ovf0), 32'd0);
        check("full_pushpop_send", 32'(bus0.opTxSend), 32'd1);
        check("full_pushpop_data", 32'(bus0.opTxData), 32'h30);
        waitDrain();
        check("ovf_log_size", 32'(log0.size()), 32'd17);
        for (int i = 0; i < DEPTH; i++)
            check($sformatf("ovf_log%0d", i), 32'(log0[i]),
                  32'(8'h30 + i));
        check("ovf_log16", 32'(log0[16]), 32'h7E);

        // Reset while in SEND with five bytes still queued.
        log0.delete();
        log1.delete();
        holdBusy = 1'b1;
        for (int i = 0; i < 6; i++) push(8'(8'h61 + i));
        check("rstq_cnt6", 32'(cnt0), 32'd6);
        holdBusy = 1'b0;
        @(negedge clk);
        check("rstq_send", 32'(bus0.opTxSend), 32'd1);
        check("rstq_cnt5", 32'(cnt0), 32'd5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstq_send_low", 32'(bus0.opTxSend), 32'd0);
        check("rstq_cnt0", 32'(cnt0), 32'd0);
        check("rstq_data0", 32'(bus0.opTxData), 32'h00);
        repeat (40) @(negedge clk);
        check("rstq_log_size", 32'(log0.size()), 32'd1);
        check("rstq_log0", 32'(log0[0]), 32'h61);
        check("rstq_idle_send", 32'(bus0.opTxSend), 32'd0);
        check("rstq_idle_cnt", 32'(cnt0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_echo_fifo.md
Name: uart_echo_fifo

Overview:
- Buffered, mode-selectable UART echo engine between the UART receiver outputs and the UART transmitter inputs.
- Received bytes enter a parametrised FIFO, so back-to-back Rx traffic is not lost while the transmitter is busy.
- Each byte is transformed on dequeue per the runtime mode; CR can optionally expand to CR+LF.
- Drives the transmitter with the level send/busy handshake; reports fill level and a sticky overflow flag.

Parameters:
- DATA_W, 8, byte width; transforms apply only when DATA_W = 8, otherwise all modes are passthrough.
- FIFO_DEPTH, 16, FIFO entries; power of two, at least 2.
- CRLF_EXPAND, 1, when 1 a dequeued 0x0D is transmitted as 0x0D followed by 0x0A.

Ports:
- ipClk, input, 1, system clock; all logic on the rising edge.
- ipReset, input, 1, synchronous, active-high reset.
- ipMode, input, 2, 0 passthrough, 1 toggle case, 2 force upper, 3 force lower.
- ipRxData, input, DATA_W, received byte.
- ipRxValid, input, 1, one-cycle strobe qualifying ipRxData.
- opTxData, output, DATA_W, byte to transmit.
- opTxSend, output, 1, transmit request (level).
- ipTxBusy, input, 1, transmitter busy.
- opFifoCount, output, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.
- opOverflow, output, 1, sticky flag: a byte was dropped.
- ipClearOverflow, input, 1, clears opOverflow.

Behaviour:
- Reset (synchronous, active-high), applied on the next clock edge:
  - FIFO emptied; opFifoCount = 0; opOverflow = 0; opTxSend = 0; opTxData = 0; lfPending = 0; FSM to IDLE.
  - Applies mid-transfer too: opTxSend drops at that edge, and the byte in flight and all queued bytes are discarded.
- Push:
  - A byte is written when ipRxValid = 1 and the FIFO is not full.
  - If the FIFO is full and no pop occurs in the same cycle, the byte is dropped and opOverflow is set.
  - Push and pop in the same cycle: both take effect, the count is unchanged, and a full FIFO does not overflow.
  - Pop on an empty FIFO never occurs; there is no write-through bypass.
- Count and pointers:
  - Pointers wrap modulo FIFO_DEPTH.
  - opFifoCount ranges 0..FIFO_DEPTH and is registered.
- Overflow flag:
  - ipClearOverflow clears opOverflow.
  - If a clear and a new overflow occur in the same cycle, the set wins.
- Transforms (applied at pop; ipMode is sampled in the pop cycle):
  - Mode 1: bytes 'A'-'Z' and 'a'-'z' are XORed with 0x20.
  - Mode 2: 'a'-'z' minus 0x20.
  - Mode 3: 'A'-'Z' plus 0x20.
  - All other bytes pass through unchanged in every mode.
- FSM states: IDLE, SEND, WAIT.
  - IDLE: if the FIFO is non-empty and ipTxBusy = 0, pop; register the transformed byte on opTxData; set opTxSend = 1; go to SEND. If CRLF_EXPAND = 1 and the popped byte is 0x0D, also set lfPending = 1.
  - SEND: hold opTxSend = 1 and opTxData stable until ipTxBusy = 1, then set opTxSend = 0 and go to WAIT. There is no timeout.
  - WAIT: when ipTxBusy = 0, either:
    - if lfPending, load opTxData = 0x0A, set opTxSend = 1, clear lfPending and go to SEND; or
    - otherwise go to IDLE.
- Latency: a byte pushed at edge N into an empty FIFO, with the transmitter idle, gives opTxSend = 1 after edge N+1.
- Ordering: bytes are transmitted in arrival order, with no gaps other than the handshake.
- Mode changes: a change of ipMode affects only bytes popped after the change.

Test Plan:
- Mode 0, push 0x41 with ipTxBusy modelled as 10 cycles busy after send → opTxData = 0x41, opTxSend high 1 cycle after push, low the cycle after busy rises, count returns to 0.
- Mode 1, push "aZ3" back-to-back → transmitted 0x41, 0x7A, 0x33 in order; opFifoCount peaks at 2 (3 when the transmitter is held busy).
- Mode 2 then mode 3: "q" gives 0x51; "Q" gives 0x71; "@" and "[" are unchanged (0x40, 0x5B).
- CRLF_EXPAND = 1, push 0x0D then 0x31 → transmitted sequence 0x0D, 0x0A, 0x31; with CRLF_EXPAND = 0 → 0x0D, 0x31.
- Hold ipTxBusy = 1 and push FIFO_DEPTH+2 bytes → count = 16, opOverflow = 1, and the last two bytes are absent from the output. Push coincident with a pop at full → no overflow. ipClearOverflow → opOverflow = 0.
- Assert ipReset while in SEND with 5 bytes queued → next edge: opTxSend = 0, count = 0, state IDLE; no further transmissions without new pushes.
